c16_ps2_receiver: RTL
=====================

// Module: c16_ps2_receiver
// PURPOSE
//  Receives device-to-host PS/2 keyboard frames and delivers bytes to the C16 keyboard matrix stage.
//  - Inputs: raw ps2_clk / ps2_dat pins.
//  - Outputs: scancode[7:0] with a one-cycle receiveflag strobe, matching the matrix stage's inputs.
//  - Receive only: no host-to-device transmission, never drives or inhibits the bus.
// PARAMETERS
//  FILTER_LEN      8      consecutive equal clk samples required before the filtered PS/2 clock changes
//  TIMEOUT_CYCLES  56000  idle clk cycles mid-frame before the frame is abandoned (~2 ms @ 28 MHz)
// PORTS
//  clk          in   1  system clock; the single clock domain
//  reset        in   1  synchronous, active-high reset
//  ps2_clk      in   1  raw PS/2 clock pin, asynchronous
//  ps2_dat      in   1  raw PS/2 data pin, asynchronous
//  scancode     out  8  last good byte received; held until the next good frame
//  receiveflag  out  1  1-cycle strobe: scancode has just been updated
//  parity_err   out  1  1-cycle strobe: frame dropped, odd parity failed
//  frame_err    out  1  1-cycle strobe: frame dropped, stop bit was 0
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; scancode=8'h00; receiveflag, parity_err, frame_err = 0.
//   - Synchronizer and filter outputs = 1 (idle bus).
//   - Reset mid-frame discards the partial frame.
//  Input conditioning:
//   - ps2_clk and ps2_dat each pass through a 2-FF synchronizer.
//   - The synced clock feeds a glitch filter: counter 0..FILTER_LEN-1, cleared whenever the sample equals clk_f.
//   - clk_f toggles only after FILTER_LEN consecutive differing samples.
//   - fall = clk_f & ~next_clk_f, registered: a 1-cycle pulse per filtered falling edge.
//   - Data is sampled from the synced ps2_dat in the cycle fall is high.
//  Frame FSM (advances only on fall):
//   - IDLE: dat=0 -> DATA, bitcnt=0. dat=1 -> stay in IDLE (false start, no flag).
//   - DATA: shreg <= {dat, shreg[7:1]} (LSB first), bitcnt++. After the 8th bit -> PARITY.
//   - PARITY: latch par. -> STOP.
//   - STOP, -> IDLE, one of:
//     - dat=1 and ^{shreg,par}=1: scancode<=shreg and receiveflag=1, on the same edge.
//     - dat=0: frame_err=1; scancode unchanged.
//     - dat=1 and parity bad: parity_err=1; scancode unchanged.
//     - Stop bit wins: if dat=0 and parity is also bad, only frame_err pulses.
//  Strobes:
//   - Each strobe is high exactly one clk cycle; at most one strobe per frame.
//   - Latency from the raw ps2_clk fall of the stop bit to receiveflag is <= FILTER_LEN+4 clk cycles.
//  Decoding:
//   - No scancode decoding; 8'hF0 and 8'hE0 prefixes are passed through as ordinary bytes.
//   - Back-to-back frames are handled with no dead time beyond the FSM returning to IDLE.
// CONFIGURATION
//  PS2_RX_TIMEOUT_EN defined:
//   - Watchdog counter cleared on every fall and held at 0 in IDLE; otherwise increments.
//   - At TIMEOUT_CYCLES-1: FSM -> IDLE, bitcnt=0, no strobe asserted.
//   - Counter width is $clog2(TIMEOUT_CYCLES).
//  PS2_RX_TIMEOUT_EN undefined:
//   - No counter; the FSM waits indefinitely for further edges.
//   - A lost edge desynchronises the frame until a bad parity/stop bit resyncs it.
// STRUCTURE
//  Shared package c16_ps2_pkg:
//   - FSM state encoding {IDLE, DATA, PARITY, STOP}.
//   - Constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0, for downstream users.
//  One sub-module, c16_ps2_line_filter (2-FF sync + glitch filter, parameter FILTER_LEN):
//   - Instantiated once, for ps2_clk.
//   - ps2_dat gets only the bare 2-FF sync.
// TESTING
//  - Send byte 8'h1C (bits LSB first, parity=0, stop=1) at 12.5 kHz -> scancode=8'h1C, receiveflag high exactly 1 cycle.
//  - Frames F0 then 1C back-to-back -> two strobes in order, scancode 8'hF0 then 8'h1C.
//  - Byte 8'h5A with parity bit inverted -> parity_err 1 cycle, no receiveflag, scancode holds its prior value.
//  - Byte 8'h29 with stop=0 -> frame_err 1 cycle; the following good frame 8'h29 is received correctly.
//  - Glitch 3 cycles low on ps2_clk (FILTER_LEN=8) while idle and mid-frame -> no bit consumed, frame still received.
//  - PS2_RX_TIMEOUT_EN: stop after 4 data bits, wait TIMEOUT_CYCLES, then send 8'h76 -> scancode=8'h76, no error strobes.
//    Without the macro, the same stimulus -> corrupted frame and an error strobe.
//  - Assert reset in the middle of a frame, then send 8'h12 -> outputs zero during reset; 8'h12 is received cleanly afterwards.

Source files
------------

// File: rtl/c16_ps2_pkg.sv
// c16_ps2_pkg
//   Types and constants shared by the C16 PS/2 receiver and its downstream users.
//   - ps2_state_t : frame FSM state encoding {IDLE, DATA, PARITY, STOP}
//   - PS2_BREAK   : break (key release) prefix byte
//   - PS2_EXT     : extended-key prefix byte
package c16_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/c16_ps2_line_filter.sv
// c16_ps2_line_filter
//   Two-flop synchronizer followed by a glitch filter for the raw PS/2 clock.
//   The filtered level only changes after FILTER_LEN consecutive synced
//   samples that differ from it; fall pulses for one cycle per filtered
//   high-to-low transition.
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous, active-high reset (filter settles to idle-high)
//     line_in  in   raw asynchronous line
//     fall     out  1-cycle pulse per filtered falling edge
module c16_ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync1;
    logic          sync2;
    logic          line_f;
    logic          next_line_f;
    logic [CW-1:0] cnt;
    logic          cnt_full;

    assign cnt_full = (cnt == CW'(FILTER_LEN - 1));

    always_comb begin
        next_line_f = line_f;
        if ((sync2 != line_f) && cnt_full)
            next_line_f = sync2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_f <= 1'b1;
            cnt    <= '0;
            fall   <= 1'b0;
        end else begin
            sync1  <= line_in;
            sync2  <= sync1;
            line_f <= next_line_f;
            fall   <= line_f & ~next_line_f;
            // Any sample matching the filtered level restarts the count,
            // so only an unbroken run of FILTER_LEN differing samples toggles it.
            if ((sync2 == line_f) || cnt_full)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/c16_ps2_receiver.sv
// c16_ps2_receiver
//   Receive-only PS/2 keyboard front end for the C16 keyboard matrix stage.
//   Never drives or inhibits the PS/2 bus. Bytes are passed through undecoded
//   (prefixes PS2_BREAK / PS2_EXT arrive as ordinary bytes).
//   Optional feature: define PS2_RX_TIMEOUT_EN to abandon a frame after
//   TIMEOUT_CYCLES idle clk cycles mid-frame.
//   Ports:
//     clk          in   system clock, single domain
//     reset        in   synchronous, active-high reset
//     ps2_clk      in   raw PS/2 clock pin (asynchronous)
//     ps2_dat      in   raw PS/2 data pin (asynchronous)
//     scancode     out  last good byte, held until the next good frame
//     receiveflag  out  1-cycle strobe: scancode just updated
//     parity_err   out  1-cycle strobe: frame dropped, odd parity failed
//     frame_err    out  1-cycle strobe: frame dropped, stop bit was 0
module c16_ps2_receiver
    import c16_ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 56000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scancode,
    output logic       receiveflag,
    output logic       parity_err,
    output logic       frame_err
);

    ps2_state_t state;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic       par;
    logic       fall;
    logic       dat_s1;
    logic       dat_s2;
    logic       timeout;

    c16_ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .line_in(ps2_clk),
        .fall   (fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (reset || fall || (state == IDLE))
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign timeout = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bitcnt      <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            scancode    <= '0;
            receiveflag <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            receiveflag <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            if (fall) begin
                case (state)
                    IDLE: begin
                        bitcnt <= '0;
                        if (!dat_s2)
                            state <= DATA;
                    end
                    DATA: begin
                        shreg  <= {dat_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        // A bad stop bit masks any parity result.
                        if (!dat_s2)
                            frame_err <= 1'b1;
                        else if (^{shreg, par}) begin
                            scancode    <= shreg;
                            receiveflag <= 1'b1;
                        end else
                            parity_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout) begin
                state  <= IDLE;
                bitcnt <= '0;
            end
        end
    end

endmodule
